// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the two-requester data-memory arbiter.
// Optional round-robin arbitration is enabled with DMEM_ARB_RR_EN (see dmem_arb_pick).
package dmem_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 11;
    localparam int DM_DEPTH = 32;
    localparam int IDX_W    = $clog2(DM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    // Any address bit above the memory index makes the access out of range.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
        return |addr[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between two requesters.
// DMEM_ARB_RR_EN defined: tie goes to the requester not granted last; undefined: r0 wins ties.
module dmem_arb_pick (
    input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
    input  logic       ptr_i,
`endif
    output logic       any_o,
    output logic       win_o
);

    always_comb begin
        any_o = |req_i;
        win_o = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // ptr_i holds the id granted last, so a tie flips away from it
        if (&req_i) win_o = ~ptr_i;
        else        win_o = req_i[1];
`else
        if (req_i[0]) win_o = 1'b0;
        else          win_o = req_i[1];
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a 32-word data memory: IDLE -> ACCESS -> RESP per access.
// Round-robin tie breaking is enabled with DMEM_ARB_RR_EN; default is fixed priority to r0.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic              dm_ena,
    output logic              dm_w,
    output logic              dm_r,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    state_e              state_q, state_d;
    logic                id_q, id_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                any_req;
    logic                win;
    logic                oor;
    logic                mem_go;

`ifdef DMEM_ARB_RR_EN
    logic                ptr_q, ptr_d;
`endif

    dmem_arb_pick u_pick (
        .req_i ({r1_req, r0_req}),
`ifdef DMEM_ARB_RR_EN
        .ptr_i (ptr_q),
`endif
        .any_o (any_req),
        .win_o (win)
    );

    assign oor    = addr_oor(addr_q);
    // rst gates the strobes directly so a reset mid-ACCESS cannot commit a write
    assign mem_go = !rst && (state_q == S_ACCESS) && !oor;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef DMEM_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                    id_d    = win;
                    we_d    = win ? r1_we    : r0_we;
                    addr_d  = win ? r1_addr  : r0_addr;
                    wdata_d = win ? r1_wdata : r0_wdata;
`ifdef DMEM_ARB_RR_EN
                    ptr_d   = win;
`endif
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (oor) begin
                    if (id_q) rdata1_d = '0;
                    else      rdata0_d = '0;
                end else if (!we_q) begin
                    if (id_q) rdata1_d = dm_rdata;
                    else      rdata0_d = dm_rdata;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign r0_gnt   = !rst && (state_q == S_ACCESS) && !id_q;
    assign r1_gnt   = !rst && (state_q == S_ACCESS) &&  id_q;
    assign r0_done  = !rst && (state_q == S_RESP)   && !id_q;
    assign r1_done  = !rst && (state_q == S_RESP)   &&  id_q;
    assign r0_err   = r0_done && oor;
    assign r1_err   = r1_done && oor;
    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;

    assign dm_ena   = mem_go;
    assign dm_w     = mem_go &&  we_q;
    assign dm_r     = mem_go && !we_q;
    assign dm_addr  = mem_go ? addr_q  : '0;
    assign dm_wdata = mem_go ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-word behavioural memory.
// Tie-order expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [10:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        dm_ena, dm_w, dm_r;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;

    logic [31:0] mem [32];
    logic        preload;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (dm_ena && dm_w) begin
            mem[dm_addr[4:0]] <= dm_wdata;
        end
    end
    // an out-of-ACCESS sample of dm_rdata would pick up this marker
    assign dm_rdata = dm_ena ? mem[dm_addr[4:0]] : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic req, input logic we,
                         input logic [10:0] addr, input logic [31:0] wd);
        if (id) begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd; end
        else    begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd; end
    endtask

    // One complete access; gc/dc stay -1 if the gnt/done never shows up.
    task automatic do_access(input logic id, input logic we, input logic [10:0] addr,
                             input logic [31:0] wd, output int sc, output int gc,
                             output int dc, output logic [31:0] rd, output logic er,
                             output int wcnt, output int ecnt, output logic [10:0] waddr);
        sc = cyc; gc = -1; dc = -1; rd = '0; er = 1'b0; wcnt = 0; ecnt = 0; waddr = '0;
        drive(id, 1'b1, we, addr, wd);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dm_ena) ecnt++;
            if (dm_ena && dm_w) begin wcnt++; waddr = dm_addr; end
            if (id ? r1_gnt : r0_gnt) begin
                gc = cyc;
                drive(id, 1'b0, we, addr, wd);
            end
            if (id ? r1_done : r0_done) begin
                dc = cyc;
                rd = id ? r1_rdata : r0_rdata;
                er = id ? r1_err : r0_err;
                break;
            end
        end
        drive(id, 1'b0, we, addr, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        tick();
        preload = 1'b0;
        tick();
        total++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err} !== 6'b0) begin
            bad++; $display("FAIL reset_hs: got %b want 000000",
                            {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err});
        end
        total++;
        if ({r0_rdata, r1_rdata} !== 64'd0) begin
            bad++; $display("FAIL reset_rdata: got %h %h want 0 0", r0_rdata, r1_rdata);
        end
        total++;
        if ({dm_ena, dm_w, dm_r, dm_addr} !== 14'd0) begin
            bad++; $display("FAIL reset_dm: got %b want 0", {dm_ena, dm_w, dm_r, dm_addr});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int sc, gc, dc, wc, ec;
        logic [31:0] rd;
        logic er;
        logic [10:0] wa;
        do_access(1'b0, 1'b1, 11'd5, 32'hDEAD_BEEF, sc, gc, dc, rd, er, wc, ec, wa);
        total++;
        if (wc !== 1 || wa !== 11'd5) begin
            bad++; $display("FAIL wr_pulse: got cnt=%0d addr=%0d want cnt=1 addr=5", wc, wa);
        end
        total++;
        if (gc - sc !== 1 || dc - gc !== 1) begin
            bad++; $display("FAIL wr_latency: got req->gnt=%0d gnt->done=%0d want 1 1",
                            gc - sc, dc - gc);
        end
        do_access(1'b0, 1'b0, 11'd5, 32'd0, sc, gc, dc, rd, er, wc, ec, wa);
        total++;
        if (dc < 0 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            bad++; $display("FAIL rd_data: got done=%0d rdata=%h err=%b want DEADBEEF err=0",
                            dc, rd, er);
        end
        total++;
        if (dc - gc !== 1 || wc !== 0) begin
            bad++; $display("FAIL rd_timing: got gnt->done=%0d writes=%0d want 1 0", dc - gc, wc);
        end
    endtask

    task automatic test_out_of_range();
        int sc, gc, dc, wc, ec;
        logic [31:0] rd;
        logic er;
        logic [10:0] wa;
        do_access(1'b1, 1'b0, 11'd7, 32'd0, sc, gc, dc, rd, er, wc, ec, wa);
        total++;
        if (rd !== 32'hA500_0007 || er !== 1'b0) begin
            bad++; $display("FAIL r1_rd7: got %h err=%b want a5000007 err=0", rd, er);
        end
        do_access(1'b1, 1'b0, 11'h020, 32'd0, sc, gc, dc, rd, er, wc, ec, wa);
        total++;
        if (ec !== 0) begin
            bad++; $display("FAIL oor_ena: got %0d enable cycles want 0", ec);
        end
        total++;
        if (dc < 0 || er !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL oor_resp: got done=%0d err=%b rdata=%h want err=1 rdata=0",
                            dc, er, rd);
        end
    endtask

    task automatic test_reset_abort();
        int sc, gc, dc, wc, ec;
        logic [31:0] rd;
        logic er;
        logic [10:0] wa;
        tick();
        drive(1'b0, 1'b1, 1'b1, 11'd3, 32'h1234_5678);
        tick();
        total++;
        if (r0_gnt !== 1'b1) begin
            bad++; $display("FAIL abort_gnt: got %b want 1", r0_gnt);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 11'd3, 32'h1234_5678);
        #1;
        total++;
        if ({dm_ena, dm_w} !== 2'b00) begin
            bad++; $display("FAIL abort_strobe: got ena,w=%b want 00", {dm_ena, dm_w});
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({r0_done, r0_gnt, dm_ena} !== 3'b000) begin
            bad++; $display("FAIL abort_idle: got done,gnt,ena=%b want 000",
                            {r0_done, r0_gnt, dm_ena});
        end
        do_access(1'b0, 1'b0, 11'd3, 32'd0, sc, gc, dc, rd, er, wc, ec, wa);
        total++;
        if (dc < 0 || rd !== 32'hA500_0003) begin
            bad++; $display("FAIL abort_keep: got %h want a5000003", rd);
        end
    endtask

    task automatic test_back_to_back();
        int gnts[$];
        int clash = 0;
        int gap_bad = 0;
        drive(1'b1, 1'b1, 1'b0, 11'd2, 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (r1_gnt) gnts.push_back(cyc);
            if ((r0_gnt && r1_gnt) || (r0_done && r1_done) || r0_gnt || r0_done) clash++;
        end
        drive(1'b1, 1'b0, 1'b0, 11'd2, 32'd0);
        tick(); tick(); tick();
        for (int i = 1; i < gnts.size(); i++) if (gnts[i] - gnts[i-1] != 3) gap_bad++;
        total++;
        if (gnts.size() < 5 || gap_bad !== 0) begin
            bad++; $display("FAIL b2b_rate: got %0d gnts %0d bad gaps want >=5 gnts 0 bad gaps",
                            gnts.size(), gap_bad);
        end
        total++;
        if (clash !== 0) begin
            bad++; $display("FAIL b2b_excl: got %0d bad cycles want 0", clash);
        end
        total++;
        if (r1_rdata !== 32'hA500_0002) begin
            bad++; $display("FAIL b2b_rdata: got %h want a5000002", r1_rdata);
        end
    endtask

    task automatic test_tie();
        int ord[4];
        int exp_ord[4];
        int n = 0;
        int c0 = 2;
        int c1 = 2;
        int clash = 0;
`ifdef DMEM_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 1, 1};
`endif
        ord = '{-1, -1, -1, -1};
        drive(1'b0, 1'b1, 1'b1, 11'd10, 32'h1111_0000);
        drive(1'b1, 1'b1, 1'b1, 11'd11, 32'h2222_0000);
        for (int i = 0; i < 24 && n < 4; i++) begin
            tick();
            if ((r0_gnt && r1_gnt) || (r0_done && r1_done)) clash++;
            if (r0_gnt) begin
                ord[n] = 0; n++; c0--;
                if (c0 == 0) drive(1'b0, 1'b0, 1'b1, 11'd10, 32'h1111_0000);
            end
            if (r1_gnt && n < 4) begin
                ord[n] = 1; n++; c1--;
                if (c1 == 0) drive(1'b1, 1'b0, 1'b1, 11'd11, 32'h2222_0000);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ord[i] !== exp_ord[i]) begin
                bad++; $display("FAIL tie_order[%0d]: got r%0d want r%0d", i, ord[i], exp_ord[i]);
            end
        end
        total++;
        if (clash !== 0) begin
            bad++; $display("FAIL tie_excl: got %0d bad cycles want 0", clash);
        end
        total++;
        if (r0_rdata !== 32'hA500_0003) begin
            bad++; $display("FAIL tie_hold: got %h want a5000003", r0_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_reset_abort();
        test_back_to_back();
        test_tie();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
